// File: rtl/fp_to_fixed_axis.sv
// AXI-Stream binary32 to signed fixed-point converter.
// Input capture register followed by unpack, align and round/saturate stages; the whole pipe stalls together.
module fp_to_fixed_axis #(
  parameter int unsigned OUT_W     = 32,
  parameter int unsigned FRAC_BITS = 16
) (
  input  logic             clk_i,
  input  logic             nrst_i,
  input  logic             s_axis_a_tvalid,
  output logic             s_axis_a_tready,
  input  logic [31:0]      s_axis_a_tdata,
  output logic             m_axis_result_tvalid,
  input  logic             m_axis_result_tready,
  output logic [OUT_W-1:0] m_axis_result_tdata,
  output logic [1:0]       m_axis_result_tuser
);

  localparam int unsigned  MAG_W      = 24 + OUT_W;
  localparam int           SHIFT_BIAS = 150 - int'(FRAC_BITS);
  localparam logic [MAG_W:0] NEG_LIM  = (MAG_W+1)'(1) << (OUT_W - 1);
  localparam logic [MAG_W:0] POS_LIM  = NEG_LIM - (MAG_W+1)'(1);
  localparam logic [OUT_W-1:0] MAX_V  = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_V  = {1'b1, {(OUT_W-1){1'b0}}};

  logic adv;

  // capture register
  logic        v0_q;
  logic [31:0] w0_q;

  // unpack/classify stage
  logic        v1_q, s1_q, nan1_q, inf1_q, zero1_q;
  logic        s1_d, nan1_d, inf1_d, zero1_d;
  logic [7:0]  e1_q, e1_d;
  logic [23:0] m1_q, m1_d;

  // align stage
  logic             v2_q, s2_q, nan2_q, ovf2_q, grd2_q;
  logic             s2_d, nan2_d, ovf2_d, grd2_d;
  logic [MAG_W-1:0] mag2_q, mag2_d;
  int               shift;

  // round/saturate stage (output register)
  logic             v3_q;
  logic [OUT_W-1:0] data_q, data_d, val;
  logic [1:0]       user_q, user_d;
  logic [MAG_W:0]   rnd, lim;

  assign adv             = ~v3_q | m_axis_result_tready;
  assign s_axis_a_tready = adv;

  assign s1_d    = w0_q[31];
  assign e1_d    = w0_q[30:23];
  assign m1_d    = {1'b1, w0_q[22:0]};
  assign nan1_d  = (w0_q[30:23] == 8'hFF) && (w0_q[22:0] != 23'd0);
  assign inf1_d  = (w0_q[30:23] == 8'hFF) && (w0_q[22:0] == 23'd0);
  assign zero1_d = (w0_q[30:23] == 8'h00);

  // Only the guard bit matters for ties-away rounding, so no sticky is carried.
  always_comb begin
    shift  = int'(e1_q) - SHIFT_BIAS;
    s2_d   = s1_q;
    nan2_d = nan1_q;
    ovf2_d = inf1_q;
    mag2_d = '0;
    grd2_d = 1'b0;
    if (!(nan1_q || inf1_q || zero1_q)) begin
      if (shift > int'(OUT_W)) begin
        ovf2_d = 1'b1;
      end else if (shift >= 0) begin
        mag2_d = MAG_W'(m1_q) << shift[5:0];
      end else if (shift >= -24) begin
        mag2_d = MAG_W'(m1_q >> 5'(-shift));
        grd2_d = m1_q[5'(-shift - 1)];
      end
    end
  end

  always_comb begin
    rnd    = (MAG_W+1)'(mag2_q) + (MAG_W+1)'(grd2_q);
    lim    = s2_q ? NEG_LIM : POS_LIM;
    val    = rnd[OUT_W-1:0];
    data_d = s2_q ? -val : val;
    user_d = 2'b00;
    if (nan2_q) begin
      data_d = '0;
      user_d = 2'b10;
    end else if (ovf2_q || (rnd > lim)) begin
      data_d = s2_q ? MIN_V : MAX_V;
      user_d = 2'b01;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      v0_q    <= 1'b0;
      w0_q    <= '0;
      v1_q    <= 1'b0;
      s1_q    <= 1'b0;
      nan1_q  <= 1'b0;
      inf1_q  <= 1'b0;
      zero1_q <= 1'b0;
      e1_q    <= '0;
      m1_q    <= '0;
      v2_q    <= 1'b0;
      s2_q    <= 1'b0;
      nan2_q  <= 1'b0;
      ovf2_q  <= 1'b0;
      grd2_q  <= 1'b0;
      mag2_q  <= '0;
      v3_q    <= 1'b0;
      data_q  <= '0;
      user_q  <= '0;
    end else if (adv) begin
      v0_q    <= s_axis_a_tvalid;
      w0_q    <= s_axis_a_tdata;
      v1_q    <= v0_q;
      s1_q    <= s1_d;
      nan1_q  <= nan1_d;
      inf1_q  <= inf1_d;
      zero1_q <= zero1_d;
      e1_q    <= e1_d;
      m1_q    <= m1_d;
      v2_q    <= v1_q;
      s2_q    <= s2_d;
      nan2_q  <= nan2_d;
      ovf2_q  <= ovf2_d;
      grd2_q  <= grd2_d;
      mag2_q  <= mag2_d;
      v3_q    <= v2_q;
      data_q  <= data_d;
      user_q  <= user_d;
    end
  end

  assign m_axis_result_tvalid = v3_q;
  assign m_axis_result_tdata  = data_q;
  assign m_axis_result_tuser  = user_q;

endmodule

// File: tb/tb_fp_to_fixed_axis.sv
// Bench for fp_to_fixed_axis: directed vectors, randomized stream with backpressure, mid-stream reset.
module tb_fp_to_fixed_axis;

  localparam int unsigned OUT_W     = 32;
  localparam int unsigned FRAC_BITS = 16;

  logic             clk_i = 1'b0;
  logic             nrst_i;
  logic             s_valid;
  logic             s_ready;
  logic [31:0]      s_data;
  logic             m_valid;
  logic             m_ready;
  logic [OUT_W-1:0] m_data;
  logic [1:0]       m_user;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0]      in_q[$];
  bit               stalled = 1'b0;
  logic [OUT_W-1:0] held_data;
  logic [1:0]       held_user;

  fp_to_fixed_axis #(.OUT_W(OUT_W), .FRAC_BITS(FRAC_BITS)) dut (
    .clk_i                (clk_i),
    .nrst_i               (nrst_i),
    .s_axis_a_tvalid      (s_valid),
    .s_axis_a_tready      (s_ready),
    .s_axis_a_tdata       (s_data),
    .m_axis_result_tvalid (m_valid),
    .m_axis_result_tready (m_ready),
    .m_axis_result_tdata  (m_data),
    .m_axis_result_tuser  (m_user)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Real-valued reference: value * 2^FRAC_BITS, round half away from zero, clamp.
  function automatic logic [33:0] model(input logic [31:0] f);
    logic       s;
    logic [7:0] e;
    real        mag, n, lim;
    longint     v;
    s = f[31];
    e = f[30:23];
    if (e == 8'hFF)
      return (f[22:0] != 0) ? {2'b10, 32'h0} : {2'b01, (s ? 32'h8000_0000 : 32'h7FFF_FFFF)};
    if (e == 8'h00)
      return 34'd0;
    mag = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** (real'(e) - 127.0 + real'(FRAC_BITS)));
    n   = $floor(mag + 0.5);
    lim = s ? (2.0 ** 31) : (2.0 ** 31) - 1.0;
    if (n > lim)
      return {2'b01, (s ? 32'h8000_0000 : 32'h7FFF_FFFF)};
    v = longint'(n);
    if (s) v = -v;
    return {2'b00, 32'(v)};
  endfunction

  function automatic logic [31:0] rand_word();
    int unsigned sel, k;
    logic [7:0]  e;
    logic [22:0] fr;
    sel = $urandom_range(0, 9);
    fr  = 23'($urandom);
    if (sel == 0) begin
      case ($urandom_range(0, 4))
        0: return 32'h7F80_0000;
        1: return 32'hFF80_0000;
        2: return {1'b0, 8'hFF, fr | 23'd1};
        3: return 32'h8000_0000;
        default: return {1'($urandom), 8'h00, fr};
      endcase
    end
    if (sel <= 3) begin
      // exact half-LSB ties
      k  = $urandom_range(1, 8);
      e  = 8'(134 - k);
      fr = (fr & ~23'((1 << k) - 1)) | 23'(1 << (k - 1));
      return {1'($urandom), e, fr};
    end
    e = 8'($urandom_range(95, 170));
    return {1'($urandom), e, fr};
  endfunction

  // Handshake observer and scoreboard, sampled midway between active edges.
  always @(negedge clk_i) begin
    if (!nrst_i) begin
      in_q.delete();
      stalled = 1'b0;
    end else begin
      logic [33:0] exp;
      if (stalled) begin
        check_eq("stall_valid", 64'(m_valid), 64'd1);
        check_eq("stall_data", 64'(m_data), 64'(held_data));
        check_eq("stall_user", 64'(m_user), 64'(held_user));
      end
      check_eq("s_ready", 64'(s_ready), 64'(!m_valid || m_ready));
      if (s_valid && s_ready) in_q.push_back(s_data);
      if (m_valid && m_ready) begin
        check_eq("out_expected", 64'(in_q.size() != 0), 64'd1);
        if (in_q.size() != 0) begin
          exp = model(in_q.pop_front());
          check_eq("out_data", 64'(m_data), 64'(exp[31:0]));
          check_eq("out_user", 64'(m_user), 64'(exp[33:32]));
        end
      end
      stalled   = m_valid && !m_ready;
      held_data = m_data;
      held_user = m_user;
    end
  end

  task automatic send_one(input logic [31:0] w, input bit rnd_rdy);
    bit acc;
    int n;
    n       = 0;
    s_valid = 1'b1;
    s_data  = w;
    forever begin
      if (rnd_rdy) m_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk_i);
      acc = s_ready;
      @(posedge clk_i);
      #1;
      if (acc) break;
      n++;
      if (n > 200) begin
        check_eq("accept_timeout", 64'(acc), 64'd1);
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic directed(input logic [31:0] w, input logic [31:0] exp_d, input logic [1:0] exp_u);
    send_one(w, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk_i);
      #1;
      check_eq($sformatf("lat%0d_%h", k, w), 64'(m_valid), 64'(k == 3));
    end
    check_eq($sformatf("dir_data_%h", w), 64'(m_data), 64'(exp_d));
    check_eq($sformatf("dir_user_%h", w), 64'(m_user), 64'(exp_u));
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int n;
    nrst_i  = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check_eq("rst_valid", 64'(m_valid), 64'd0);
    check_eq("rst_data", 64'(m_data), 64'd0);
    check_eq("rst_user", 64'(m_user), 64'd0);
    nrst_i = 1'b1;
    @(posedge clk_i);
    #1;

    directed(32'h3E20_D97C, 32'h0000_2836, 2'b00);
    directed(32'h3F80_0000, 32'h0001_0000, 2'b00);
    directed(32'hC020_0000, 32'hFFFD_8000, 2'b00);
    directed(32'hC700_0000, 32'h8000_0000, 2'b00);
    directed(32'h4780_0000, 32'h7FFF_FFFF, 2'b01);
    directed(32'hFF80_0000, 32'h8000_0000, 2'b01);
    directed(32'h7FC0_0000, 32'h0000_0000, 2'b10);
    directed(32'h3700_0000, 32'h0000_0001, 2'b00);
    directed(32'hB700_0000, 32'hFFFF_FFFF, 2'b00);
    directed(32'h0040_0000, 32'h0000_0000, 2'b00);
    directed(32'h8000_0000, 32'h0000_0000, 2'b00);
    directed(32'hB680_0000, 32'h0000_0000, 2'b00);

    for (int i = 0; i < 64; i++) send_one(rand_word(), 1'b1);
    m_ready = 1'b1;
    n = 0;
    while (in_q.size() != 0 && n < 50) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    check_eq("drain_empty", 64'(in_q.size()), 64'd0);

    send_one(32'h3F80_0000, 1'b0);
    send_one(32'hC020_0000, 1'b0);
    send_one(32'h4000_0000, 1'b0);
    nrst_i = 1'b0;
    @(posedge clk_i);
    #1;
    nrst_i = 1'b1;
    check_eq("flush_valid", 64'(m_valid), 64'd0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk_i);
      #1;
      check_eq($sformatf("flush_quiet%0d", k), 64'(m_valid), 64'd0);
    end

    directed(32'h3F80_0000, 32'h0001_0000, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
